// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage: run-state encoding, next-PC select codes
// and default widths.
package instr_fetch_pkg;

    localparam int PC_W_DEF     = 11;
    localparam int CT_W_DEF     = 16;
    localparam int RS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RUN    = 2'd2,
        S_HALTED = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_INC    = 2'd1,
        SEL_TARGET = 2'd2,
        SEL_RET    = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/instr_fetch_return_stack.sv
// Hardware return stack for Call/Ret: LIFO with synchronous clear.
// Over/underflow policy is left to the owner; this block just refuses the operation.
module instr_fetch_return_stack
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH  = RS_DEPTH_DEF,
    parameter int DATA_W = PC_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_push_data,
    output logic [DATA_W-1:0] o_top,
    output logic              o_full,
    output logic              o_empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_wr_idx  = r_sp[IDX_W-1:0];
    assign w_top_idx = w_wr_idx - 1'b1;
    assign o_empty   = (r_sp == '0);
    assign o_full    = (r_sp == SP_W'(DEPTH));
    assign o_top     = r_mem[w_top_idx];

    // Pop wins over push; clear wins over both.
    assign w_do_pop  = i_pop && !o_empty && !i_clr;
    assign w_do_push = i_push && !i_pop && !o_full && !i_clr;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_sp <= '0;
        end else if (w_do_pop) begin
            r_sp <= r_sp - 1'b1;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_do_push) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Program-counter / fetch-control stage: Start/Halt/Done run handshake,
// next-PC selection, Call/Ret via a return stack, and a saturating run-cycle counter.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = 0,
    parameter int RS_DEPTH   = RS_DEPTH_DEF,
    parameter int CT_W       = CT_W_DEF
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic            i_halt,
    input  logic            i_stall,
    input  logic            i_jump,
    input  logic            i_branch,
    input  logic            i_cond,
    input  logic            i_call,
    input  logic            i_ret,
    input  logic [PC_W-1:0] i_target,
    output logic [PC_W-1:0] o_pc,
    output logic            o_running,
    output logic            o_done,
    output logic            o_err,
    output logic [CT_W-1:0] o_cycle_ct
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic [CT_W-1:0] r_ct;
    logic            r_err;
    logic            r_running;
    logic            r_done;

    pc_sel_e         w_sel;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_next;
    logic            w_push_req;
    logic            w_pop_req;
    logic            w_err_set;
    logic            w_run_step;
    logic            w_rs_push;
    logic            w_rs_pop;
    logic            w_rs_clr;
    logic [PC_W-1:0] w_rs_top;
    logic            w_rs_full;
    logic            w_rs_empty;

    assign w_pc_inc   = r_pc + 1'b1;
    assign w_run_step = (r_state == S_RUN) && !i_start;
    assign w_rs_push  = w_run_step && w_push_req;
    assign w_rs_pop   = w_run_step && w_pop_req;
    // Stack is emptied on the edge that enters ARMED and on every ARMED cycle.
    assign w_rs_clr   = i_start || (r_state == S_ARMED);

    always_comb begin
        w_sel      = SEL_INC;
        w_push_req = 1'b0;
        w_pop_req  = 1'b0;
        w_err_set  = 1'b0;
        if (i_stall || i_halt) begin
            w_sel = SEL_HOLD;
        end else if (i_ret) begin
            if (w_rs_empty) begin
                w_err_set = 1'b1;
            end else begin
                w_sel     = SEL_RET;
                w_pop_req = 1'b1;
            end
        end else if (i_call) begin
            w_sel = SEL_TARGET;
            if (w_rs_full) begin
                w_err_set = 1'b1;
            end else begin
                w_push_req = 1'b1;
            end
        end else if (i_jump || (i_branch && i_cond)) begin
            w_sel = SEL_TARGET;
        end
    end

    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_sel)
            SEL_HOLD:   w_pc_next = r_pc;
            SEL_INC:    w_pc_next = w_pc_inc;
            SEL_TARGET: w_pc_next = i_target;
            SEL_RET:    w_pc_next = w_rs_top;
            default:    w_pc_next = w_pc_inc;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_pc      <= START_PC;
            r_ct      <= '0;
            r_err     <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_ARMED;
                        r_pc    <= START_PC;
                        r_ct    <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_ARMED: begin
                    r_pc  <= START_PC;
                    r_ct  <= '0;
                    r_err <= 1'b0;
                    if (!i_start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_start) begin
                        r_state   <= S_ARMED;
                        r_pc      <= START_PC;
                        r_ct      <= '0;
                        r_err     <= 1'b0;
                        r_running <= 1'b0;
                    end else begin
                        r_pc <= w_pc_next;
                        if (r_ct != '1) begin
                            r_ct <= r_ct + 1'b1;
                        end
                        if (w_err_set) begin
                            r_err <= 1'b1;
                        end
                        if (i_halt && !i_stall) begin
                            r_state   <= S_HALTED;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    if (i_start) begin
                        r_state <= S_ARMED;
                        r_pc    <= START_PC;
                        r_ct    <= '0;
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    instr_fetch_return_stack #(
        .DEPTH  (RS_DEPTH),
        .DATA_W (PC_W)
    ) u_return_stack (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_rs_push),
        .i_pop       (w_rs_pop),
        .i_clr       (w_rs_clr),
        .i_push_data (w_pc_inc),
        .o_top       (w_rs_top),
        .o_full      (w_rs_full),
        .o_empty     (w_rs_empty)
    );

    assign o_pc       = r_pc;
    assign o_running  = r_running;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_cycle_ct = r_ct;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-based reference model checked every cycle,
// plus literal expectations at each scenario step.
module tb_instr_fetch;

    localparam int PC_W   = 11;
    localparam int CT_W   = 16;
    localparam int DEPTH  = 4;
    localparam int PC_MOD = 2048;
    localparam int CT_MAX = 65535;

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_RUN    = 2;
    localparam int M_HALTED = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, halt, stall, jump, branch, cond, call, ret;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
    logic            running, done, err;
    logic [CT_W-1:0] cycle_ct;

    int errors = 0;
    int checks = 0;

    int m_state = M_IDLE;
    int m_pc    = 0;
    int m_ct    = 0;
    bit m_err   = 1'b0;
    int m_stk[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_halt     (halt),
        .i_stall    (stall),
        .i_jump     (jump),
        .i_branch   (branch),
        .i_cond     (cond),
        .i_call     (call),
        .i_ret      (ret),
        .i_target   (target),
        .o_pc       (pc),
        .o_running  (running),
        .o_done     (done),
        .o_err      (err),
        .o_cycle_ct (cycle_ct)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic void model_arm();
        m_state = M_ARMED;
        m_pc    = 0;
        m_ct    = 0;
        m_err   = 1'b0;
        m_stk.delete();
    endfunction

    // Reference model: spec rules with a queue as the stack and modular arithmetic for PC.
    always @(posedge clk) begin
        if (reset) begin
            m_state = M_IDLE;
            m_pc    = 0;
            m_ct    = 0;
            m_err   = 1'b0;
            m_stk.delete();
        end else begin
            case (m_state)
                M_IDLE:   if (start) model_arm();
                M_ARMED: begin
                    model_arm();
                    if (!start) m_state = M_RUN;
                end
                M_RUN: begin
                    if (start) begin
                        model_arm();
                    end else begin
                        if (m_ct < CT_MAX) m_ct++;
                        if (stall) begin
                        end else if (halt) begin
                            m_state = M_HALTED;
                        end else if (ret) begin
                            if (m_stk.size() == 0) begin
                                m_err = 1'b1;
                                m_pc  = (m_pc + 1) % PC_MOD;
                            end else begin
                                m_pc = m_stk.pop_back();
                            end
                        end else if (call) begin
                            if (m_stk.size() == DEPTH) m_err = 1'b1;
                            else m_stk.push_back((m_pc + 1) % PC_MOD);
                            m_pc = int'(target);
                        end else if (jump || (branch && cond)) begin
                            m_pc = int'(target);
                        end else begin
                            m_pc = (m_pc + 1) % PC_MOD;
                        end
                    end
                end
                M_HALTED: if (start) model_arm();
                default:  m_state = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_pc", int'(pc), m_pc);
            chk("model_running", int'(running), int'(m_state == M_RUN));
            chk("model_done", int'(done), int'(m_state == M_HALTED));
            chk("model_err", int'(err), int'(m_err));
            chk("model_cycle_ct", int'(cycle_ct), m_ct);
        end
    end

    // Drive one cycle of strobes just after an edge, return just after the next edge.
    task automatic cyc(input bit st, input bit hl, input bit sl, input bit jp, input bit br,
                       input bit cd, input bit cl, input bit rt, input int tg);
        start  = st;
        halt   = hl;
        stall  = sl;
        jump   = jp;
        branch = br;
        cond   = cd;
        call   = cl;
        ret    = rt;
        target = PC_W'(tg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int call_tg[5];
        int ret_pc[5];
        call_tg = '{27, 34, 39, 51, 76};
        ret_pc  = '{40, 35, 28, 75, 76};
        reset = 1'b1;
        start = 0; halt = 0; stall = 0; jump = 0; branch = 0; cond = 0; call = 0; ret = 0;
        target = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_pc", int'(pc), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_ct", int'(cycle_ct), 0);

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("armed_pc", int'(pc), 0);
        chk("armed_running", int'(running), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("launch_running", int'(running), 1);
        chk("launch_pc", int'(pc), 0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk("seq_pc", int'(pc), i);
        end

        cyc(0, 0, 0, 1, 0, 0, 0, 0, 19);
        chk("jump_pc", int'(pc), 19);
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 74);
        chk("branch_nt_pc", int'(pc), 20);
        cyc(0, 0, 0, 0, 1, 1, 0, 0, 74);
        chk("branch_t_pc", int'(pc), 74);

        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0, call_tg[i]);
            chk("call_pc", int'(pc), call_tg[i]);
            chk("call_err", int'(err), (i == 4) ? 1 : 0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk("ret_pc", int'(pc), ret_pc[i]);
            chk("ret_err", int'(err), 1);
        end

        cyc(0, 0, 0, 1, 0, 0, 0, 0, 83);
        chk("jump83_pc", int'(pc), 83);
        cyc(0, 0, 1, 1, 0, 0, 0, 0, 200);
        chk("stall_jump_pc", int'(pc), 83);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("halt_stall_pc", int'(pc), 83);
        chk("halt_stall_running", int'(running), 1);
        chk("halt_stall_done", int'(done), 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("halted_done", int'(done), 1);
        chk("halted_running", int'(running), 0);
        chk("halted_pc", int'(pc), 83);
        chk("halted_ct", int'(cycle_ct), 22);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("halted_hold_pc", int'(pc), 83);
        chk("halted_hold_ct", int'(cycle_ct), 22);
        chk("halted_hold_done", int'(done), 1);

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("restart_pc", int'(pc), 0);
        chk("restart_done", int'(done), 0);
        chk("restart_err", int'(err), 0);
        chk("restart_ct", int'(cycle_ct), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("relaunch_running", int'(running), 1);

        cyc(0, 0, 0, 1, 0, 0, 0, 0, 'h7FF);
        chk("to_max_pc", int'(pc), 'h7FF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", int'(pc), 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 'h7FF);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 100);
        chk("call_at_max_pc", int'(pc), 100);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("ret_wrapped_pc", int'(pc), 0);
        chk("ret_wrapped_err", int'(err), 0);

        cyc(0, 0, 0, 0, 0, 0, 1, 0, 10);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 20);
        chk("two_calls_pc", int'(pc), 20);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 30);
        chk("abort_pc", int'(pc), 0);
        chk("abort_running", int'(running), 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("abort_launch_running", int'(running), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("abort_ret_err", int'(err), 1);
        chk("abort_ret_pc", int'(pc), 1);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
